// File: rtl/hazard_scoreboard.sv
// Pipeline-hazard scoreboard beside ID: tracks in-flight rd writers, raises stalls, drives forwarding selects.
// Optional HAZARD_FWD_EN enables forwarding; without it any dependency younger than the last slot stalls.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16,
  localparam int RW = $clog2(NREG),
  localparam int SW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [RW-1:0]    issue_rd,
  input  logic             issue_rd_we,
  input  logic             issue_is_load,
  input  logic [RW-1:0]    issue_rs1,
  input  logic [RW-1:0]    issue_rs2,
  input  logic             issue_rs1_used,
  input  logic             issue_rs2_used,
  input  logic             issue_rs2_late,
  input  logic             flush,
  output logic             stall,
  output logic [SW-1:0]    fwd_rs1_sel,
  output logic [SW-1:0]    fwd_rs2_sel,
  output logic             fwd_rs2_at_mem,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_load;
  logic [RW-1:0]    slot_rd [DEPTH];

  logic accept;
  logic hit1, hit2, load1, load2;
  int   k1, k2;
  logic hazard;

  assign accept = issue_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
      slot_load  <= '0;
      for (int k = 0; k < DEPTH; k++) slot_rd[k] <= '0;
    end else begin
      slot_valid <= {slot_valid[DEPTH-2:0], accept & issue_rd_we & (issue_rd != '0)};
      slot_load  <= {slot_load[DEPTH-2:0], issue_is_load};
      slot_rd[0] <= issue_rd;
      for (int k = 1; k < DEPTH; k++) slot_rd[k] <= slot_rd[k-1];
    end
  end

  // Scan oldest to youngest so the youngest matching writer is the one left standing.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    load1 = 1'b0;
    load2 = 1'b0;
    k1    = 0;
    k2    = 0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (issue_rs1_used && slot_valid[k] && slot_rd[k] == issue_rs1) begin
        hit1  = 1'b1;
        k1    = k;
        load1 = slot_load[k];
      end
      if (issue_rs2_used && slot_valid[k] && slot_rd[k] == issue_rs2) begin
        hit2  = 1'b1;
        k2    = k;
        load2 = slot_load[k];
      end
    end
  end

`ifdef HAZARD_FWD_EN
  int j1, j2;

  // Store data consumed in MEM gets one extra stage of slack before it must be forwarded.
  always_comb begin
    fwd_rs1_sel    = '0;
    fwd_rs2_sel    = '0;
    fwd_rs2_at_mem = 1'b0;
    hazard         = 1'b0;
    j1             = 0;
    j2             = 0;
    if (hit1) begin
      j1 = k1 + 1;
      if (j1 <= DEPTH-1) fwd_rs1_sel = SW'(j1);
      if (load1 && j1 < LOAD_LAT) hazard = 1'b1;
    end
    if (hit2) begin
      if (issue_rs2_late && (k2 + 2 <= DEPTH-1)) begin
        j2             = k2 + 2;
        fwd_rs2_at_mem = 1'b1;
      end else begin
        j2 = k2 + 1;
      end
      if (j2 <= DEPTH-1) fwd_rs2_sel = SW'(j2);
      if (load2 && j2 < LOAD_LAT) hazard = 1'b1;
    end
  end
`else
  logic unused_fwd;

  assign fwd_rs1_sel    = '0;
  assign fwd_rs2_sel    = '0;
  assign fwd_rs2_at_mem = 1'b0;
  // Only the write-first register file helps: a writer in the last slot is already visible.
  assign hazard = (hit1 && k1 <= DEPTH-2) || (hit2 && k2 <= DEPTH-2);
  assign unused_fwd = ^{load1, load2, issue_rs2_late, (LOAD_LAT > 1)};
`endif

  assign stall = issue_valid & ~flush & hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: age-based model (cycle stamps per register) checked every cycle,
// plus directed instruction sequences with literal expectations for both HAZARD_FWD_EN builds.
module tb_hazard_scoreboard;
  localparam int NREG = 32, DEPTH = 3, LOAD_LAT = 2, CNT_W = 16;
  localparam int RW = $clog2(NREG), SW = $clog2(DEPTH);
`ifdef HAZARD_FWD_EN
  localparam int PRE_CNT = 1, NEAR_SEL = 1;
`else
  localparam int PRE_CNT = 2, NEAR_SEL = 0;
`endif

  typedef struct packed {
    logic          st;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
    logic          am;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid, issue_rd_we, issue_is_load;
  logic [RW-1:0]    issue_rd, issue_rs1, issue_rs2;
  logic             issue_rs1_used, issue_rs2_used, issue_rs2_late, flush;
  logic             stall, fwd_rs2_at_mem;
  logic [SW-1:0]    fwd_rs1_sel, fwd_rs2_sel;
  logic [CNT_W-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_cnt = 0;
  int last_wr [NREG];
`ifdef HAZARD_FWD_EN
  bit last_ld [NREG];
`endif
  exp_t e;

  hazard_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rs2_late(issue_rs2_late), .flush(flush), .stall(stall), .fwd_rs1_sel(fwd_rs1_sel),
    .fwd_rs2_sel(fwd_rs2_sel), .fwd_rs2_at_mem(fwd_rs2_at_mem), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Age of the latest writer of r, in slots since it left ID; -1 when it is no longer tracked.
  function automatic int age_of(input logic [RW-1:0] r);
    int a;
    a = cyc - last_wr[r] - 1;
    if (r == '0 || a < 0 || a > DEPTH-1) return -1;
    return a;
  endfunction

  function automatic exp_t model();
    exp_t r;
    int   a1, a2;
    bit   haz;
`ifdef HAZARD_FWD_EN
    int   j;
`endif
    r   = '0;
    haz = 1'b0;
    a1  = issue_rs1_used ? age_of(issue_rs1) : -1;
    a2  = issue_rs2_used ? age_of(issue_rs2) : -1;
`ifdef HAZARD_FWD_EN
    if (a1 >= 0) begin
      j = a1 + 1;
      if (j <= DEPTH-1) r.s1 = SW'(j);
      if (last_ld[issue_rs1] && j > 0 && j < LOAD_LAT) haz = 1'b1;
    end
    if (a2 >= 0) begin
      if (issue_rs2_late && a2 + 2 <= DEPTH-1) begin
        j    = a2 + 2;
        r.am = 1'b1;
      end else begin
        j = a2 + 1;
      end
      if (j <= DEPTH-1) r.s2 = SW'(j);
      if (last_ld[issue_rs2] && j > 0 && j < LOAD_LAT) haz = 1'b1;
    end
`else
    haz = (a1 >= 0 && a1 <= DEPTH-2) || (a2 >= 0 && a2 <= DEPTH-2);
`endif
    r.st = issue_valid && !flush && haz;
    return r;
  endfunction

  always_comb e = model();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        last_wr[r] <= -1000;
`ifdef HAZARD_FWD_EN
        last_ld[r] <= 1'b0;
`endif
      end
      m_cnt <= 0;
    end else begin
      if (issue_valid && !flush && !e.st && issue_rd_we && issue_rd != '0) begin
        last_wr[issue_rd] <= cyc;
`ifdef HAZARD_FWD_EN
        last_ld[issue_rd] <= issue_is_load;
`endif
      end
      if (e.st && m_cnt < (1 << CNT_W) - 1) m_cnt <= m_cnt + 1;
      cyc <= cyc + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input int req);
    total++;
    if (act !== 32'(req)) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cyc_stall", 32'(stall), int'(e.st));
    checkOutput("cyc_rs1_sel", 32'(fwd_rs1_sel), int'(e.s1));
    checkOutput("cyc_rs2_sel", 32'(fwd_rs2_sel), int'(e.s2));
    checkOutput("cyc_at_mem", 32'(fwd_rs2_at_mem), int'(e.am));
    checkOutput("cyc_count", 32'(stall_cycles), m_cnt);
  end

  task automatic applyStimulus(input int v, input int rd, input int we, input int ld,
                               input int rs1, input int u1, input int rs2, input int u2,
                               input int late, input int fl);
    @(posedge clk);
    #1;
    issue_valid    = v[0];
    issue_rd       = RW'(rd);
    issue_rd_we    = we[0];
    issue_is_load  = ld[0];
    issue_rs1      = RW'(rs1);
    issue_rs1_used = u1[0];
    issue_rs2      = RW'(rs2);
    issue_rs2_used = u2[0];
    issue_rs2_late = late[0];
    flush          = fl[0];
    #1;
  endtask

  task automatic expectIssue(input string name, input int st, input int s1, input int s2, input int am);
    checkOutput({name, "_stall"}, 32'(stall), st);
    checkOutput({name, "_rs1_sel"}, 32'(fwd_rs1_sel), s1);
    checkOutput({name, "_rs2_sel"}, 32'(fwd_rs2_sel), s2);
    checkOutput({name, "_at_mem"}, 32'(fwd_rs2_at_mem), am);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    {issue_valid, issue_rd_we, issue_is_load, issue_rs1_used, issue_rs2_used, issue_rs2_late, flush} = '0;
    issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    #1 rst = 1'b0;
    #1;
    expectIssue("reset", 0, 0, 0, 0);
    checkOutput("reset_count", 32'(stall_cycles), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

`ifdef HAZARD_FWD_EN
    applyStimulus(1, 1, 1, 1, 2, 1, 0, 0, 0, 0);      // lw x1,4(x2)
    expectIssue("lw", 0, 0, 0, 0);
    applyStimulus(1, 5, 1, 0, 1, 1, 1, 1, 0, 0);      // add x5,x1,x1
    expectIssue("loaduse_hold", 1, 1, 1, 0);
    applyStimulus(1, 5, 1, 0, 1, 1, 1, 1, 0, 0);
    expectIssue("loaduse_go", 0, 2, 2, 0);
    checkOutput("loaduse_count", 32'(stall_cycles), 1);
    applyStimulus(1, 1, 1, 1, 2, 1, 0, 0, 0, 0);      // lw x1,4(x2)
    applyStimulus(1, 0, 0, 0, 3, 1, 1, 1, 1, 0);      // sw x1,4(x3)
    expectIssue("store_data", 0, 0, 2, 1);
    applyStimulus(1, 1, 1, 0, 2, 1, 3, 1, 0, 0);      // add x1,x2,x3
    applyStimulus(1, 4, 1, 0, 1, 1, 0, 1, 0, 0);      // add x4,x1,x0
    expectIssue("alu_adjacent", 0, 1, 0, 0);
    applyStimulus(1, 6, 1, 0, 2, 1, 3, 1, 0, 0);      // add x6,x2,x3
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 4, 1, 0, 6, 1, 0, 1, 0, 0);      // add x4,x6,x0
    expectIssue("alu_gap1", 0, 2, 0, 0);
    applyStimulus(1, 7, 1, 0, 2, 1, 3, 1, 0, 0);      // add x7,x2,x3
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 4, 1, 0, 7, 1, 0, 1, 0, 0);      // add x4,x7,x0
    expectIssue("alu_gap2", 0, 0, 0, 0);
`else
    applyStimulus(1, 1, 1, 0, 2, 1, 3, 1, 0, 0);      // add x1,x2,x3
    expectIssue("alu_w", 0, 0, 0, 0);
    applyStimulus(1, 4, 1, 0, 1, 1, 0, 1, 0, 0);      // add x4,x1,x0
    expectIssue("nofwd_hold1", 1, 0, 0, 0);
    applyStimulus(1, 4, 1, 0, 1, 1, 0, 1, 0, 0);
    expectIssue("nofwd_hold2", 1, 0, 0, 0);
    applyStimulus(1, 4, 1, 0, 1, 1, 0, 1, 0, 0);
    expectIssue("nofwd_go", 0, 0, 0, 0);
    checkOutput("nofwd_count", 32'(stall_cycles), 2);
`endif

    applyStimulus(1, 0, 1, 0, 5, 0, 0, 0, 0, 0);      // writer of x0
    applyStimulus(1, 9, 1, 0, 0, 1, 0, 1, 0, 0);      // reader of x0
    expectIssue("x0_read", 0, 0, 0, 0);
    applyStimulus(1, 8, 1, 1, 2, 1, 0, 0, 0, 1);      // lw x8 flushed in ID
    expectIssue("flush_lw", 0, 0, 0, 0);
    applyStimulus(1, 10, 1, 0, 8, 1, 8, 1, 0, 0);     // add x10,x8,x8
    expectIssue("after_flush_lw", 0, 0, 0, 0);
    applyStimulus(1, 11, 1, 1, 2, 1, 0, 0, 0, 0);     // lw x11
    applyStimulus(1, 12, 1, 0, 11, 1, 11, 1, 0, 1);   // add x12,x11,x11 flushed
    expectIssue("flush_hazard", 0, NEAR_SEL, NEAR_SEL, 0);
    checkOutput("flush_count", 32'(stall_cycles), PRE_CNT);
    applyStimulus(1, 13, 1, 0, 12, 1, 12, 1, 0, 0);   // add x13,x12,x12
    expectIssue("after_flush_add", 0, 0, 0, 0);
    applyStimulus(1, 14, 1, 1, 2, 1, 0, 0, 0, 0);     // lw x14
    applyStimulus(1, 15, 1, 0, 14, 1, 14, 1, 0, 0);   // add x15,x14,x14
    expectIssue("pre_reset", 1, NEAR_SEL, NEAR_SEL, 0);
    rst = 1'b0;
    #1;
    expectIssue("async_reset", 0, 0, 0, 0);
    checkOutput("async_reset_count", 32'(stall_cycles), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(1, 15, 1, 0, 14, 1, 14, 1, 0, 0);
    expectIssue("post_reset", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Parametrised pipeline-hazard scoreboard for the RV32I pipelined core. It sits beside the ID stage.
- It tracks in-flight destination registers in a shift register of DEPTH slots and decides whether the instruction in ID must stall.
- It also drives the forwarding-mux selects for rs1 and rs2, including late (MEM-stage) consumption of store data, so that lw→sw needs no stall.
- It generalises the fixed 5-stage load-use/store-data hazard handling to configurable depth, load latency and register count, and adds a stall-cycle counter.

## Interface
Parameters:
- NREG, 32: architectural register count; RW = $clog2(NREG).
- DEPTH, 3: tracked slots (slot 0 = EX, 1 = MEM, 2 = WB); DEPTH ≥ 3; SW = $clog2(DEPTH).
- LOAD_LAT, 2: first slot index whose stage output holds load data; 1 ≤ LOAD_LAT ≤ DEPTH-1.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- issue_valid  in  1  ID holds a valid instruction.
- issue_rd  in  RW  destination register.
- issue_rd_we  in  1  instruction writes rd.
- issue_is_load  in  1  instruction is a load.
- issue_rs1, issue_rs2  in  RW  source registers.
- issue_rs1_used, issue_rs2_used  in  1  source operand is read.
- issue_rs2_late  in  1  rs2 is consumed in MEM (store data).
- flush  in  1  kill the instruction in ID (taken branch/jump).
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- fwd_rs1_sel, fwd_rs2_sel  out  SW  0 = register file; j>0 = forward from the output of slot j.
- fwd_rs2_at_mem  out  1  fwd_rs2_sel applies at the MEM-stage store-data mux (else at EX).
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

## Operation
- Each slot holds {valid, rd, is_load}.
- Every cycle slots shift k→k+1; the slot DEPTH-1 entry drops out.
- Slot 0 loads the ID instruction when issue_valid & !stall & !flush, with valid = issue_rd_we & (issue_rd != 0). Otherwise slot 0 loads a bubble (valid=0).
- Match on source s at slot k: slot valid & rd == s & s_used. Match k = youngest (lowest k) matching slot; older matches are ignored.
- Register file is write-first, so a slot DEPTH-1 writer is visible to an ID read.
- Early consumer (rs1, or rs2 with rs2_late=0): j = k+1. Select = j if j ≤ DEPTH-1, else 0.
- Late consumer (rs2_late=1): j = k+2.
  - If j ≤ DEPTH-1: fwd_rs2_sel = j, fwd_rs2_at_mem = 1.
  - Otherwise the early rule applies with fwd_rs2_at_mem = 0.
- Load hazard: the match slot is_load and the chosen j satisfies 0 < j < LOAD_LAT.
- stall = issue_valid & !flush & (load hazard on rs1 or rs2).
- While stall=1, selects still reflect the current match; the datapath ignores them.
- No match: selects 0, fwd_rs2_at_mem 0.
- stall_cycles increments on every cycle with stall=1 and saturates at 2^CNT_W-1.

## Timing
- Reset (rst=0, asynchronous): all slots invalid, stall_cycles = 0. Outputs: stall 0, selects 0, fwd_rs2_at_mem 0.
- Outputs are combinational from slot state and issue inputs within the cycle.
- A stall lasts until the writer shifts far enough: one cycle for default load-use.
- flush together with a hazard: flush wins, stall = 0, bubble inserted.
- rd = x0 never produces a match.

## Configuration
- HAZARD_FWD_EN defined: forwarding and stall rules as above.
- HAZARD_FWD_EN undefined (no forwarding paths): all selects and fwd_rs2_at_mem are tied to 0. stall = issue_valid & !flush & (match at any k ≤ DEPTH-2 on any used source), regardless of is_load or rs2_late.

## Test plan
- Reset: drive rst=0 mid-run with slots full → stall=0, selects=0, stall_cycles=0 immediately, before a clock edge.
- Load-use: lw x1,4(x2) then add x5,x1,x1 → stall=1 for exactly 1 cycle. Then fwd_rs1_sel=fwd_rs2_sel=2, stall_cycles=1.
- Store data: lw x1,4(x2) then sw x1,4(x3) with x3 unmatched → stall=0, fwd_rs2_sel=2, fwd_rs2_at_mem=1, fwd_rs1_sel=0.
- ALU chain: add x1 then add x4,x1,x0 → fwd_rs1_sel=1. With one nop between → sel 2; with two nops → sel 0; no stall in any case.
- x0 and flush: writer rd=x0 followed by a reader of x0 → sel 0, no stall. Then flush asserted on a load-use pair → stall=0 and the flushed lw never occupies slot 0.
- HAZARD_FWD_EN undefined: add x1 then add x4,x1,x0 → stall 2 cycles, stall_cycles=2, selects 0.
